piece_ctrl: RTL and testbench
=============================

PIECE_CTRL -- requirements
Module: piece_ctrl

Interface
REQ-001 Parameter SPAWN_X, default 5'd8, column written to blk_x at spawn.
REQ-002 Parameter SPAWN_Y, default 5'd0, row written to blk_y at spawn.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  one-cycle pulse; begins a game from IDLE or GAMEOVER.
REQ-006 cmd_valid / cmd_ready  in / out  1 / 1  user-move handshake; transfer when both high.
REQ-007 cmd  in  2  move code: 0 left, 1 right, 2 rotate clockwise, 3 soft drop.
REQ-008 grav_tick  in  1  one-cycle gravity pulse.
REQ-009 piece_valid / piece_ready  in / out  1 / 1  next-piece handshake.
REQ-010 piece  in  16  next 4x4 piece bitmap, bit 0 top-left, row-major.
REQ-011 blk_rot  in  16  clockwise rotation of blk, produced by the external rotator.
REQ-012 chk_block, chk_x, chk_y  out  16, 5, 5  candidate placement presented to the external field checker.
REQ-013 chk_fail  in  1  combinational; high when the candidate overlaps the field or leaves the 20x20 field.
REQ-014 blk, blk_x, blk_y  out  16, 5, 5  committed active piece and position.
REQ-015 lock_req / lock_ack  out / in  1 / 1  merge request to field owner; lock_req held until lock_ack.
REQ-016 game_over  out  1  high in GAMEOVER.
REQ-017 lock_cnt  out  16  pieces locked since start; saturates at 16'hFFFF.

Function
REQ-018 States: IDLE, SPAWN, CHKSPAWN, READY, CHECK, LOCK, GAMEOVER.
REQ-019 IDLE -> SPAWN on start; GAMEOVER -> SPAWN on start; start is ignored in all other states.
REQ-020 SPAWN: piece_ready=1; on piece_valid, latch blk=piece, blk_x=SPAWN_X, blk_y=SPAWN_Y; -> CHKSPAWN.
REQ-021 CHKSPAWN: present the latched placement on chk_*; chk_fail=1 -> GAMEOVER, else -> READY.
REQ-022 READY: cmd_ready=1 only in READY and only when no gravity move is pending.
REQ-023 A grav_tick arriving in any state other than IDLE or GAMEOVER sets the grav_pend flag.
REQ-024 READY with grav_pend set -> CHECK with a down move and clears grav_pend; a command is not accepted that cycle.
REQ-025 READY with a command accepted -> CHECK with the command's move.
REQ-026 Gravity has priority over a simultaneous command; the command stays unaccepted, with cmd_ready low.
REQ-027 Candidate per move: left x-1; right x+1; rotate block=blk_rot; down and soft drop y+1. All arithmetic is 5-bit unsigned.
REQ-028 Candidates that wrap are presented unchanged, and chk_fail is required to reject them: left at x=0 gives x=31.
REQ-029 CHECK lasts exactly 1 cycle; chk_fail is sampled at the end of it.
REQ-030 CHECK with chk_fail=0: commit candidate to blk/blk_x/blk_y; -> READY.
REQ-031 CHECK with chk_fail=1 on left, right or rotate: no change; -> READY; the move is silently dropped.
REQ-032 CHECK with chk_fail=1 on down or soft drop: -> LOCK.
REQ-033 LOCK: lock_req=1 with blk/blk_x/blk_y stable; on lock_ack, lock_cnt+1 (saturating); -> SPAWN.
REQ-034 Outside CHKSPAWN and CHECK, chk_* mirror blk/blk_x/blk_y.
REQ-035 Move latency: a command accepted in cycle n is visible on blk_* in cycle n+2.
REQ-036 In IDLE and GAMEOVER: grav_tick and cmd_valid are ignored, and the ready outputs and lock_req are low.
REQ-037 start from GAMEOVER clears lock_cnt and grav_pend.

Reset
REQ-038 reset_n low asynchronously forces: state IDLE, blk=0, blk_x=SPAWN_X, blk_y=SPAWN_Y, grav_pend=0, lock_cnt=0, all handshake outputs 0, game_over=0.
REQ-039 Reset asserted mid-CHECK or mid-LOCK abandons the operation; there is no lock_req after release.
REQ-040 The first state change after reset release requires a start pulse.

Verification
REQ-041 start, piece=16'h0660, chk_fail=0 -> blk_x=8, blk_y=0, state READY; cmd=0 accepted -> blk_x=7 two cycles later.
REQ-042 In READY, cmd=1 and grav_tick in the same cycle -> down move first (blk_y=1), cmd_ready low; the right move is accepted afterwards (blk_x=9).
REQ-043 cmd=2 with chk_fail=1 in CHECK -> blk unchanged, back to READY, no lock_req.
REQ-044 Down move with chk_fail=1 -> lock_req held until lock_ack delayed 3 cycles; then lock_cnt=1 and piece_ready=1.
REQ-045 Spawn with chk_fail=1 -> game_over=1; further grav_tick and cmd ignored; start -> SPAWN with lock_cnt=0.
REQ-046 reset_n pulsed low during LOCK -> IDLE immediately, lock_req=0, lock_cnt=0.

Source files
------------

// File: rtl/piece_ctrl.sv
//------------------------------------------------------------------------------
// Module   : piece_ctrl
// Purpose  : Controls the active falling piece. It spawns a piece, applies
//            user moves and gravity, asks an external field checker whether
//            each move is legal, and asks the field owner to merge a piece
//            that can no longer fall.
// Revision : 1.0 - initial release
//
// Ports
//   clk, reset_n             clock, asynchronous active-low reset
//   start                    pulse; begins a game from IDLE or GAMEOVER
//   cmd_valid/cmd_ready/cmd  user-move handshake
//                            (0 left, 1 right, 2 rotate cw, 3 soft drop)
//   grav_tick                gravity pulse
//   piece_valid/piece_ready  next-piece handshake, piece = 4x4 bitmap
//   blk_rot                  clockwise rotation of blk (external rotator)
//   chk_block/chk_x/chk_y    candidate placement shown to the field checker
//   chk_fail                 checker verdict for the candidate (combinational)
//   blk/blk_x/blk_y          committed active piece and position
//   lock_req/lock_ack        merge request, held until acknowledged
//   game_over                high while in GAMEOVER
//   lock_cnt                 pieces locked since start, saturating
//------------------------------------------------------------------------------
`default_nettype none

module piece_ctrl #(
    parameter logic [4:0] SPAWN_X = 5'd8,
    parameter logic [4:0] SPAWN_Y = 5'd0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd,
    input  logic        grav_tick,
    input  logic        piece_valid,
    output logic        piece_ready,
    input  logic [15:0] piece,
    input  logic [15:0] blk_rot,
    output logic [15:0] chk_block,
    output logic [4:0]  chk_x,
    output logic [4:0]  chk_y,
    input  logic        chk_fail,
    output logic [15:0] blk,
    output logic [4:0]  blk_x,
    output logic [4:0]  blk_y,
    output logic        lock_req,
    input  logic        lock_ack,
    output logic        game_over,
    output logic [15:0] lock_cnt
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SPAWN    = 3'd1,
        S_CHKSPAWN = 3'd2,
        S_READY    = 3'd3,
        S_CHECK    = 3'd4,
        S_LOCK     = 3'd5,
        S_GAMEOVER = 3'd6
    } state_t;

    // Move codes share the cmd encoding; gravity reuses the soft-drop code
    // because both move the piece down and both lock on failure.
    localparam logic [1:0] MV_LEFT  = 2'd0;
    localparam logic [1:0] MV_RIGHT = 2'd1;
    localparam logic [1:0] MV_ROT   = 2'd2;
    localparam logic [1:0] MV_DOWN  = 2'd3;

    state_t      state;
    logic [1:0]  move;
    logic        grav_pend;

    logic [15:0] cand_blk;
    logic [4:0]  cand_x;
    logic [4:0]  cand_y;

    // Candidate placement. Wrap-around is deliberate: a left move at x=0
    // yields x=31, which the field checker rejects as out of field.
    always_comb begin
        cand_blk = blk;
        cand_x   = blk_x;
        cand_y   = blk_y;
        case (move)
            MV_LEFT:  cand_x   = blk_x - 5'd1;
            MV_RIGHT: cand_x   = blk_x + 5'd1;
            MV_ROT:   cand_blk = blk_rot;
            default:  cand_y   = blk_y + 5'd1;
        endcase
    end

    // CHKSPAWN needs no mux: the spawned piece is already latched in blk.
    assign chk_block = (state == S_CHECK) ? cand_blk : blk;
    assign chk_x     = (state == S_CHECK) ? cand_x   : blk_x;
    assign chk_y     = (state == S_CHECK) ? cand_y   : blk_y;

    // A tick arriving this very cycle also blocks acceptance so that
    // gravity wins over a simultaneous command.
    assign cmd_ready   = (state == S_READY) && !grav_pend && !grav_tick;
    assign piece_ready = (state == S_SPAWN);
    assign lock_req    = (state == S_LOCK);
    assign game_over   = (state == S_GAMEOVER);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            move      <= MV_DOWN;
            grav_pend <= 1'b0;
            blk       <= 16'd0;
            blk_x     <= SPAWN_X;
            blk_y     <= SPAWN_Y;
            lock_cnt  <= 16'd0;
        end else begin
            // Record gravity whenever a game is in progress; READY consumes it.
            if (grav_tick && (state != S_IDLE) && (state != S_GAMEOVER)) begin
                grav_pend <= 1'b1;
            end

            case (state)
                S_IDLE, S_GAMEOVER: begin
                    if (start) begin
                        state     <= S_SPAWN;
                        lock_cnt  <= 16'd0;
                        grav_pend <= 1'b0;
                    end
                end

                S_SPAWN: begin
                    if (piece_valid) begin
                        blk   <= piece;
                        blk_x <= SPAWN_X;
                        blk_y <= SPAWN_Y;
                        state <= S_CHKSPAWN;
                    end
                end

                S_CHKSPAWN: begin
                    state <= chk_fail ? S_GAMEOVER : S_READY;
                end

                S_READY: begin
                    if (grav_pend) begin
                        move      <= MV_DOWN;
                        state     <= S_CHECK;
                        // A fresh tick in this cycle stays pending.
                        grav_pend <= grav_tick;
                    end else if (cmd_valid && cmd_ready) begin
                        move  <= cmd;
                        state <= S_CHECK;
                    end
                end

                S_CHECK: begin
                    if (!chk_fail) begin
                        blk   <= cand_blk;
                        blk_x <= cand_x;
                        blk_y <= cand_y;
                        state <= S_READY;
                    end else if (move == MV_DOWN) begin
                        state <= S_LOCK;
                    end else begin
                        state <= S_READY;
                    end
                end

                S_LOCK: begin
                    if (lock_ack) begin
                        if (lock_cnt != 16'hFFFF) begin
                            lock_cnt <= lock_cnt + 16'd1;
                        end
                        state <= S_SPAWN;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_piece_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tb_piece_ctrl
// Purpose  : Self-checking bench for piece_ctrl. A bench-side model of the
//            piece position predicts every committed move; predictions are
//            queued with the cycle they must appear on blk_* and compared by
//            a monitor when that cycle arrives.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_piece_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd;
    logic        grav_tick;
    logic        piece_valid;
    logic        piece_ready;
    logic [15:0] piece;
    logic [15:0] blk_rot;
    logic [15:0] chk_block;
    logic [4:0]  chk_x;
    logic [4:0]  chk_y;
    logic        chk_fail;
    logic [15:0] blk;
    logic [4:0]  blk_x;
    logic [4:0]  blk_y;
    logic        lock_req;
    logic        lock_ack;
    logic        game_over;
    logic [15:0] lock_cnt;

    always #5 clk = ~clk;

    piece_ctrl #(
        .SPAWN_X (5'd8),
        .SPAWN_Y (5'd0)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd         (cmd),
        .grav_tick   (grav_tick),
        .piece_valid (piece_valid),
        .piece_ready (piece_ready),
        .piece       (piece),
        .blk_rot     (blk_rot),
        .chk_block   (chk_block),
        .chk_x       (chk_x),
        .chk_y       (chk_y),
        .chk_fail    (chk_fail),
        .blk         (blk),
        .blk_x       (blk_x),
        .blk_y       (blk_y),
        .lock_req    (lock_req),
        .lock_ack    (lock_ack),
        .game_over   (game_over),
        .lock_cnt    (lock_cnt)
    );

    // External rotator: new[r][c] = old[3-c][r], bit index = row*4 + col.
    function automatic logic [15:0] rot_cw(input logic [15:0] b);
        logic [15:0] o;
        o = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                o[r*4 + c] = b[(3-c)*4 + r];
        return o;
    endfunction

    assign blk_rot = rot_cw(blk);

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Scoreboard of predicted committed placements.
    typedef struct {
        int          due;
        logic [15:0] b;
        logic [4:0]  x;
        logic [4:0]  y;
    } exp_t;

    exp_t sb[$];

    // Bench model of the committed piece.
    logic [15:0] m_blk;
    logic [4:0]  m_x;
    logic [4:0]  m_y;
    int          exp_cnt;

    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            check_val("sb_due", cyc, e.due);
            check_val("sb_blk", blk, e.b);
            check_val("sb_x", blk_x, e.x);
            check_val("sb_y", blk_y, e.y);
        end
    end

    task automatic push_exp(input int due);
        exp_t e;
        e.due = due;
        e.b   = m_blk;
        e.x   = m_x;
        e.y   = m_y;
        sb.push_back(e);
    endtask

    task automatic start_pulse();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        #1;
        check_val("start_spawn", piece_ready, 1'b1);
    endtask

    task automatic do_spawn(input logic [15:0] p, input bit fail);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (piece_ready) begin
                seen = 1'b1;
                break;
            end
        end
        check_val("spawn_piece_ready", seen, 1'b1);
        piece_valid = 1'b1;
        piece       = p;
        @(negedge clk);
        piece_valid = 1'b0;
        #1;
        check_val("chkspawn_block", chk_block, p);
        check_val("chkspawn_x", chk_x, 5'd8);
        check_val("chkspawn_y", chk_y, 5'd0);
        check_val("chkspawn_pready", piece_ready, 1'b0);
        chk_fail = fail;
        @(negedge clk);
        chk_fail = 1'b0;
        #1;
        m_blk = p;
        m_x   = 5'd8;
        m_y   = 5'd0;
        if (fail) begin
            check_val("spawn_gameover", game_over, 1'b1);
        end else begin
            check_val("spawn_ready", cmd_ready, 1'b1);
            check_val("spawn_blk", blk, p);
        end
    endtask

    task automatic send_cmd(input logic [1:0] c, input bit fail);
        bit          acc;
        logic [15:0] cb;
        logic [4:0]  cx;
        logic [4:0]  cy;
        @(negedge clk);
        cmd       = c;
        cmd_valid = 1'b1;
        acc       = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) begin
            #1;
            if (cmd_ready) acc = 1'b1;
            else @(negedge clk);
        end
        if (!acc) begin
            check_val("cmd_accept", acc, 1'b1);
            cmd_valid = 1'b0;
            return;
        end
        cb = m_blk;
        cx = m_x;
        cy = m_y;
        case (c)
            2'd0:    cx = m_x - 5'd1;
            2'd1:    cx = m_x + 5'd1;
            2'd2:    cb = rot_cw(m_blk);
            default: cy = m_y + 5'd1;
        endcase
        if (!fail) begin
            m_blk = cb;
            m_x   = cx;
            m_y   = cy;
        end
        push_exp(cyc + 2);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk_fail  = fail;
        #1;
        check_val("cand_block", chk_block, cb);
        check_val("cand_x", chk_x, cx);
        check_val("cand_y", chk_y, cy);
        @(negedge clk);
        chk_fail = 1'b0;
    endtask

    task automatic send_tick(input bit fail);
        logic [4:0] cy;
        @(negedge clk);
        grav_tick = 1'b1;
        #1;
        check_val("tick_cmd_ready", cmd_ready, 1'b0);
        cy = m_y + 5'd1;
        if (!fail) m_y = cy;
        push_exp(cyc + 3);
        @(negedge clk);
        grav_tick = 1'b0;
        @(negedge clk);
        chk_fail = fail;
        #1;
        check_val("grav_cand_y", chk_y, cy);
        @(negedge clk);
        chk_fail = 1'b0;
    endtask

    // Entered in the first LOCK cycle; acknowledges in the third.
    task automatic do_lock();
        #1;
        check_val("lock_req_c1", lock_req, 1'b1);
        @(negedge clk);
        check_val("lock_req_c2", lock_req, 1'b1);
        check_val("lock_blk_y", blk_y, m_y);
        @(negedge clk);
        check_val("lock_req_c3", lock_req, 1'b1);
        lock_ack = 1'b1;
        @(negedge clk);
        lock_ack = 1'b0;
        #1;
        check_val("lock_req_done", lock_req, 1'b0);
        check_val("lock_next_spawn", piece_ready, 1'b1);
        check_val("lock_cnt", lock_cnt, exp_cnt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n     = 1'b0;
        start       = 1'b0;
        cmd_valid   = 1'b0;
        cmd         = 2'd0;
        grav_tick   = 1'b0;
        piece_valid = 1'b0;
        piece       = 16'd0;
        chk_fail    = 1'b0;
        lock_ack    = 1'b0;
        exp_cnt     = 0;
        m_blk       = 16'd0;
        m_x         = 5'd8;
        m_y         = 5'd0;

        repeat (2) @(negedge clk);
        check_val("rst_blk", blk, 16'd0);
        check_val("rst_x", blk_x, 5'd8);
        check_val("rst_y", blk_y, 5'd0);
        check_val("rst_cnt", lock_cnt, 16'd0);
        check_val("rst_pready", piece_ready, 1'b0);
        check_val("rst_cready", cmd_ready, 1'b0);
        check_val("rst_lreq", lock_req, 1'b0);
        check_val("rst_gover", game_over, 1'b0);

        // Nothing happens without start, even with activity on inputs.
        reset_n   = 1'b1;
        grav_tick = 1'b1;
        cmd_valid = 1'b1;
        repeat (3) @(negedge clk);
        grav_tick = 1'b0;
        cmd_valid = 1'b0;
        check_val("idle_pready", piece_ready, 1'b0);
        check_val("idle_cready", cmd_ready, 1'b0);

        start_pulse();
        do_spawn(16'h0660, 1'b0);
        send_cmd(2'd0, 1'b0);                       // left -> x=7

        // Gravity and a right command in the same cycle: gravity first.
        @(negedge clk);
        cmd       = 2'd1;
        cmd_valid = 1'b1;
        grav_tick = 1'b1;
        #1;
        check_val("prio_cready_t0", cmd_ready, 1'b0);
        m_y = m_y + 5'd1;
        push_exp(cyc + 3);
        @(negedge clk);
        grav_tick = 1'b0;
        #1;
        check_val("prio_cready_t1", cmd_ready, 1'b0);
        send_cmd(2'd1, 1'b0);                       // right accepted afterwards

        send_cmd(2'd2, 1'b1);                       // rejected rotate is dropped
        #1;
        check_val("rot_drop_lreq", lock_req, 1'b0);
        check_val("rot_drop_ready", cmd_ready, 1'b1);

        send_cmd(2'd3, 1'b0);                       // soft drop
        while (m_x != 5'd0) send_cmd(2'd0, 1'b0);
        send_cmd(2'd0, 1'b1);                       // candidate wraps to 31
        send_cmd(2'd1, 1'b0);
        send_tick(1'b0);

        send_tick(1'b1);                            // down blocked -> lock
        exp_cnt = 1;
        do_lock();

        do_spawn(16'h0027, 1'b0);
        send_cmd(2'd2, 1'b0);                       // asymmetric rotation
        send_cmd(2'd3, 1'b1);                       // blocked soft drop locks
        exp_cnt = 2;
        do_lock();

        do_spawn(16'h0F00, 1'b1);                   // spawn blocked
        check_val("go_cnt_kept", lock_cnt, 16'd2);
        @(negedge clk);
        grav_tick = 1'b1;
        cmd_valid = 1'b1;
        cmd       = 2'd1;
        #1;
        check_val("go_cready", cmd_ready, 1'b0);
        @(negedge clk);
        grav_tick = 1'b0;
        cmd_valid = 1'b0;
        #1;
        check_val("go_stays", game_over, 1'b1);
        check_val("go_pready", piece_ready, 1'b0);
        check_val("go_lreq", lock_req, 1'b0);
        check_val("go_blk_x", blk_x, 5'd8);
        start_pulse();
        check_val("restart_cnt", lock_cnt, 16'd0);
        check_val("restart_gover", game_over, 1'b0);

        exp_cnt = 0;
        do_spawn(16'h0660, 1'b0);
        send_tick(1'b1);
        exp_cnt = 1;
        do_lock();
        do_spawn(16'h0660, 1'b0);
        send_tick(1'b1);
        #1;
        check_val("pre_rst_lreq", lock_req, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        check_val("midlock_lreq", lock_req, 1'b0);
        check_val("midlock_cnt", lock_cnt, 16'd0);
        check_val("midlock_blk", blk, 16'd0);
        check_val("midlock_pready", piece_ready, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check_val("post_rst_lreq", lock_req, 1'b0);
        check_val("post_rst_pready", piece_ready, 1'b0);

        check_val("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
